// File: rtl/fb_display_480p.sv
// 640x480 display controller with a paletted framebuffer: timing counters, a
// single-port-write/registered-read RAM, a 16-entry CLUT and a clear engine.
module fb_display_480p #(
    parameter int                      CORDW        = 16,
    parameter int                      FB_WIDTH     = 160,
    parameter int                      FB_HEIGHT    = 120,
    parameter int                      FB_DATAW     = 4,
    parameter int                      CLUT_COLORW  = 12,
    parameter logic [CLUT_COLORW-1:0]  BG_COLR      = 12'h137,
    parameter string                   PALETTE_FILE = ""
) (
    input  logic                                    clk_pix,
    input  logic                                    rst_pix_n,
    input  logic                                    fb_we,
    input  logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]   fb_addr_write,
    input  logic [FB_DATAW-1:0]                     fb_data_in,
    input  logic                                    fb_clear,
    input  logic [FB_DATAW-1:0]                     fb_clear_value,
    output logic                                    fb_ready,
    output logic signed [CORDW-1:0]                 sdl_sx,
    output logic signed [CORDW-1:0]                 sdl_sy,
    output logic                                    sdl_de,
    output logic                                    sdl_hsync,
    output logic                                    sdl_vsync,
    output logic [7:0]                              sdl_r,
    output logic [7:0]                              sdl_g,
    output logic [7:0]                              sdl_b,
    output logic                                    frame,
    output logic                                    line
);
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDRW  = $clog2(FB_PIXELS);

    localparam int H_FP = 16, H_SYNC = 96, H_BP = 48, H_ACT = 640;
    localparam int V_FP = 10, V_SYNC = 2,  V_BP = 33, V_ACT = 480;

    // Blanking sits at negative coordinates so the active area starts at 0.
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
    localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_ACT - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
    localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_ACT - 1);
    localparam logic signed [CORDW-1:0] FB_W_S = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] FB_H_S = CORDW'(FB_HEIGHT);
    localparam logic [FB_ADDRW-1:0]     FB_LAST = FB_ADDRW'(FB_PIXELS - 1);

    logic signed [CORDW-1:0] sx, sy;
    logic hsync_raw, vsync_raw, de_raw, win_raw;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sx <= H_STA;
            sy <= V_STA;
        end else if (sx == HA_END) begin
            sx <= H_STA;
            sy <= (sy == VA_END) ? V_STA : sy + CORDW'(1);
        end else begin
            sx <= sx + CORDW'(1);
        end
    end

    assign hsync_raw = ~(sx >= HS_STA && sx < HS_END);
    assign vsync_raw = ~(sy >= VS_STA && sy < VS_END);
    assign de_raw    = !sx[CORDW-1] && !sy[CORDW-1];
    assign win_raw   = de_raw && (sx < FB_W_S) && (sy < FB_H_S);
    assign frame     = (sx == H_STA) && (sy == V_STA);
    assign line      = (sx == H_STA);

    // Clear engine
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
    clr_state_t          clr_state;
    logic [FB_ADDRW-1:0] clr_addr;
    logic [FB_DATAW-1:0] clr_val;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            clr_state <= CLR_IDLE;
            fb_ready  <= 1'b1;
            clr_addr  <= '0;
            clr_val   <= '0;
        end else begin
            case (clr_state)
                CLR_IDLE: if (fb_clear) begin
                    clr_state <= CLR_RUN;
                    fb_ready  <= 1'b0;
                    clr_addr  <= '0;
                    clr_val   <= fb_clear_value;
                end
                CLR_RUN: if (clr_addr == FB_LAST) begin
                    clr_state <= CLR_IDLE;
                    fb_ready  <= 1'b1;
                end else begin
                    clr_addr <= clr_addr + FB_ADDRW'(1);
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end

    // Write port: the clear owns it while running; a clear request drops a user write.
    logic                ram_we;
    logic [FB_ADDRW-1:0] ram_wa;
    logic [FB_DATAW-1:0] ram_wd;

    always_comb begin
        ram_we = 1'b0;
        ram_wa = fb_addr_write;
        ram_wd = fb_data_in;
        if (clr_state == CLR_RUN) begin
            ram_we = 1'b1;
            ram_wa = clr_addr;
            ram_wd = clr_val;
        end else if (fb_we && !fb_clear && fb_addr_write < FB_ADDRW'(FB_PIXELS)) begin
            ram_we = 1'b1;
        end
    end

    logic [FB_DATAW-1:0] fb_mem [FB_PIXELS];

    always_ff @(posedge clk_pix) begin
        if (ram_we) fb_mem[ram_wa] <= ram_wd;
    end

    logic [FB_ADDRW-1:0] rd_addr;

    always_comb begin
        rd_addr = '0;
        if (win_raw)
            rd_addr = FB_ADDRW'(FB_ADDRW'(sy) * FB_ADDRW'(FB_WIDTH) + FB_ADDRW'(sx));
    end

    logic [CLUT_COLORW-1:0] clut [16];

    generate
        for (genvar i = 0; i < 16; i++) begin : g_ent
            assign clut[i] = CLUT_COLORW'({3{4'(i)}});
        end
    endgenerate

    // Stage 1: RAM data, stage 2: CLUT colour, stage 3: outputs.
    logic [FB_DATAW-1:0]     fb_rd;
    logic [CLUT_COLORW-1:0]  clut_colr;
    logic signed [CORDW-1:0] sx_p [2];
    logic signed [CORDW-1:0] sy_p [2];
    logic [1:0]              de_p, hs_p, vs_p, win_p;
    logic [CLUT_COLORW-1:0]  paint;

    assign paint = win_p[1] ? clut_colr : BG_COLR;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            fb_rd     <= '0;
            clut_colr <= '0;
            sx_p      <= '{default: '0};
            sy_p      <= '{default: '0};
            de_p      <= '0;
            hs_p      <= '1;  // syncs idle high so no false pulse leaves the pipe
            vs_p      <= '1;
            win_p     <= '0;
            sdl_sx    <= '0;
            sdl_sy    <= '0;
            sdl_de    <= 1'b0;
            sdl_hsync <= 1'b1;
            sdl_vsync <= 1'b1;
            sdl_r     <= '0;
            sdl_g     <= '0;
            sdl_b     <= '0;
        end else begin
            fb_rd     <= fb_mem[rd_addr];
            clut_colr <= clut[fb_rd];
            sx_p      <= '{sx, sx_p[0]};
            sy_p      <= '{sy, sy_p[0]};
            de_p      <= {de_p[0], de_raw};
            hs_p      <= {hs_p[0], hsync_raw};
            vs_p      <= {vs_p[0], vsync_raw};
            win_p     <= {win_p[0], win_raw};
            sdl_sx    <= sx_p[1];
            sdl_sy    <= sy_p[1];
            sdl_de    <= de_p[1];
            sdl_hsync <= hs_p[1];
            sdl_vsync <= vs_p[1];
            sdl_r     <= {2{paint[11:8]}};
            sdl_g     <= {2{paint[7:4]}};
            sdl_b     <= {2{paint[3:0]}};
        end
    end
endmodule

// File: tb/tb_fb_display_480p.sv
// Directed bench for fb_display_480p: timing counts, pixel table, clear engine
// and mid-frame reset, all against hand-computed values (default grey palette).
module tb_fb_display_480p;
    logic              clk_pix = 1'b0;
    logic              rst_pix_n = 1'b0;
    logic              fb_we = 1'b0;
    logic [14:0]       fb_addr_write = '0;
    logic [3:0]        fb_data_in = '0;
    logic              fb_clear = 1'b0;
    logic [3:0]        fb_clear_value = '0;
    logic              fb_ready;
    logic signed [15:0] sdl_sx, sdl_sy;
    logic              sdl_de, sdl_hsync, sdl_vsync;
    logic [7:0]        sdl_r, sdl_g, sdl_b;
    logic              frame, line;

    fb_display_480p dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .fb_we(fb_we),
        .fb_addr_write(fb_addr_write), .fb_data_in(fb_data_in),
        .fb_clear(fb_clear), .fb_clear_value(fb_clear_value), .fb_ready(fb_ready),
        .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
        .sdl_hsync(sdl_hsync), .sdl_vsync(sdl_vsync),
        .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b),
        .frame(frame), .line(line)
    );

    always #5 clk_pix = ~clk_pix;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        do_wr;
        logic [14:0] addr;
        logic [3:0]  data;
        logic        chk;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        de;
    } pix_vec_t;

    pix_vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    // Advance until the delayed coordinates reach (x,y), then compare the pixel.
    task automatic check_pix(input string name, input int x, input int y,
                             input logic [23:0] rgb, input logic de);
        int n = 0;
        while (!(int'(sdl_sx) == x && int'(sdl_sy) == y) && n < 60000) begin
            step();
            n++;
        end
        if (n >= 60000) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting for pixel (%0d,%0d)", name, x, y);
        end else begin
            chk(name, {sdl_r, sdl_g, sdl_b, sdl_de}, {rgb, de});
        end
    endtask

    initial begin
        int n_line, n_frame, n_hs, n_vs, gap_err, last_line, n;

        vecs[0]  = '{1'b1, 15'd1,     4'h6, 1'b0,   0,  0, 24'h000000, 1'b0};
        vecs[1]  = '{1'b1, 15'd19200, 4'h3, 1'b1,  -1,  0, 24'h113377, 1'b0};
        vecs[2]  = '{1'b1, 15'd0,     4'hF, 1'b1,   0,  0, 24'hFFFFFF, 1'b1};
        vecs[3]  = '{1'b1, 15'd1,     4'h7, 1'b1,   1,  0, 24'h777777, 1'b1};
        vecs[4]  = '{1'b1, 15'd159,   4'h1, 1'b1, 159,  0, 24'h111111, 1'b1};
        vecs[5]  = '{1'b0, 15'd0,     4'h0, 1'b1, 160,  0, 24'h113377, 1'b1};
        vecs[6]  = '{1'b1, 15'd161,   4'h5, 1'b1,   1,  1, 24'h555555, 1'b1};
        vecs[7]  = '{1'b0, 15'd0,     4'h0, 1'b1,   2,  1, 24'h222222, 1'b1};
        vecs[8]  = '{1'b0, 15'd0,     4'h0, 1'b1,   3,  1, 24'h222222, 1'b1};
        vecs[9]  = '{1'b0, 15'd0,     4'h0, 1'b1,   4,  1, 24'h222222, 1'b1};
        vecs[10] = '{1'b1, 15'd1605,  4'hE, 1'b1,   5, 10, 24'hEEEEEE, 1'b1};

        repeat (3) step();
        chk("rst_rgb",   {sdl_r, sdl_g, sdl_b}, 24'h0);
        chk("rst_sxy",   {sdl_sx, sdl_sy, sdl_de}, 33'h0);
        chk("rst_syncs", {sdl_hsync, sdl_vsync, fb_ready}, 3'b111);
        chk("rst_pulse", {frame, line}, 2'b11);

        rst_pix_n = 1'b1;
        n_line = 0; n_frame = 0; n_hs = 0; n_vs = 0; gap_err = 0; last_line = -800;
        for (int c = 0; c < 10000; c++) begin
            if (line) begin
                if (c - last_line != 800) gap_err++;
                last_line = c;
                n_line++;
            end
            if (frame) n_frame++;
            if (!sdl_hsync) n_hs++;
            if (!sdl_vsync) n_vs++;
            step();
        end
        chk("line_cnt", n_line, 13);
        chk("line_gap", gap_err, 0);
        chk("frame_cnt", n_frame, 1);
        chk("hsync_low", n_hs, 1248);
        chk("vsync_low", n_vs, 1600);

        // Clear with a colliding write; stray writes/clears during it are ignored.
        chk("ready_pre", fb_ready, 1);
        fb_clear = 1'b1; fb_clear_value = 4'h2;
        fb_we = 1'b1; fb_addr_write = 15'd163; fb_data_in = 4'hA;
        step();
        fb_clear = 1'b0; fb_we = 1'b0;
        n = 0;
        while (!fb_ready && n < 25000) begin
            n++;
            if (n == 100) begin fb_we = 1'b1; fb_addr_write = 15'd162; fb_data_in = 4'h9; end
            if (n == 200) begin fb_clear = 1'b1; fb_clear_value = 4'h7; end
            step();
            fb_we = 1'b0; fb_clear = 1'b0;
        end
        chk("clear_len", n, 19200);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) begin
                fb_we = 1'b1; fb_addr_write = vecs[i].addr; fb_data_in = vecs[i].data;
                step();
                fb_we = 1'b0;
            end
        end
        for (int i = 0; i < 11; i++)
            if (vecs[i].chk)
                check_pix($sformatf("pix_%0d_%0d", vecs[i].x, vecs[i].y),
                          vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].de);

        // Start a clear, let it write addresses 0..9, then reset mid-frame.
        fb_clear = 1'b1; fb_clear_value = 4'h4;
        step();
        fb_clear = 1'b0;
        repeat (10) @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b0;
        #1;
        chk("mid_rst_out", {sdl_r, sdl_sx, sdl_hsync}, 25'h1);
        chk("mid_rst_ready", fb_ready, 1);
        repeat (3) step();
        rst_pix_n = 1'b1;
        step();
        step();
        chk("rel_e2_sxy", {sdl_sx, sdl_sy}, 32'h0);
        step();
        chk("rel_e3_sx", int'(sdl_sx), -160);
        chk("rel_e3_sy", int'(sdl_sy), -45);
        step();
        chk("rel_e4_sx", int'(sdl_sx), -159);
        chk("rel_ready", fb_ready, 1);

        check_pix("abort_0_0", 0, 0, 24'h444444, 1'b1);
        check_pix("abort_1_0", 1, 0, 24'h444444, 1'b1);
        check_pix("keep_159_0", 159, 0, 24'h111111, 1'b1);
        check_pix("keep_1_1", 1, 1, 24'h555555, 1'b1);
        check_pix("keep_2_1", 2, 1, 24'h222222, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_display_480p.md
FB_DISPLAY_480P -- requirements
Module: fb_display_480p

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- CORDW, 16, signed screen-coordinate width.
- FB_WIDTH, 160, framebuffer width in pixels.
- FB_HEIGHT, 120, framebuffer height in pixels.
- FB_DATAW, 4, bits per framebuffer pixel (CLUT index).
- CLUT_COLORW, 12, palette entry width (4-bit R,G,B).
- BG_COLR, 12'h137, colour outside the framebuffer window.
- PALETTE_FILE, "", hex palette init file.
REQ-002 One clock; reset is asynchronous and active-low. Ports are listed as name, direction, width, meaning:
- clk_pix, in, 1, pixel clock; every register uses its rising edge.
- rst_pix_n, in, 1, asynchronous active-low reset.
- fb_we, in, 1, framebuffer write strobe.
- fb_addr_write, in, FB_ADDRW=$clog2(FB_WIDTH*FB_HEIGHT)=15, write address.
- fb_data_in, in, FB_DATAW, write data.
- fb_clear, in, 1, start-clear pulse.
- fb_clear_value, in, FB_DATAW, fill value used by a clear.
- fb_ready, out, 1, high when no clear is running.
- sdl_sx, out, CORDW signed, delayed horizontal position.
- sdl_sy, out, CORDW signed, delayed vertical position.
- sdl_de, out, 1, delayed data enable.
- sdl_hsync, out, 1, delayed hsync, active-low.
- sdl_vsync, out, 1, delayed vsync, active-low.
- sdl_r, out, 8, red channel.
- sdl_g, out, 8, green channel.
- sdl_b, out, 8, blue channel.
- frame, out, 1, undelayed one-cycle start-of-frame pulse.
- line, out, 1, undelayed one-cycle start-of-line pulse.

Function
REQ-003 Timing SHALL be 640x480: 800 clocks per line, 525 lines per frame.
REQ-004 Horizontal timing SHALL be front porch 16, sync 96, back porch 48; vertical timing SHALL be front porch 10, sync 2, back porch 33.
REQ-005 Counter sx SHALL run -160..639 and wrap to -160; sy SHALL increment when sx wraps, run -45..479, and wrap to -45.
REQ-006 Raw hsync SHALL be low for sx in [-144,-48); raw vsync SHALL be low for sy in [-35,-33).
REQ-007 Raw de SHALL be 1 when sx>=0 and sy>=0.
REQ-008 frame SHALL be 1 only when sx==-160 and sy==-45; line SHALL be 1 when sx==-160.
REQ-009 The framebuffer SHALL be a FB_WIDTH*FB_HEIGHT x FB_DATAW RAM with one synchronous write port and one registered read port (1-cycle latency).
REQ-010 On a same-address read/write in the same cycle, the read SHALL return the old data.
REQ-011 A write with fb_we=1 and fb_addr_write >= FB_WIDTH*FB_HEIGHT SHALL be ignored.
REQ-012 Window: 0<=sx<FB_WIDTH and 0<=sy<FB_HEIGHT; inside it the read address SHALL be sy*FB_WIDTH+sx, otherwise 0.
REQ-013 Stage 1 SHALL register the RAM data; stage 2 SHALL register the CLUT colour; stage 3 SHALL register the outputs.
REQ-014 Total pixel latency SHALL be 3 cycles: sdl_sx, sdl_sy, sdl_de, sdl_hsync and sdl_vsync carry the counter values delayed 3 cycles, aligned with the colour.
REQ-015 CLUT: 16 x CLUT_COLORW synchronous ROM loaded from PALETTE_FILE; if the name is empty, entry i SHALL be {i,i,i}.
REQ-016 Paint colour SHALL be the CLUT output when the pixel was inside the window (window flag pipelined alongside), else BG_COLR.
REQ-017 Each 4-bit channel c SHALL be output as {c,c} (e.g. 4'h3 -> 8'h33).
REQ-018 Clear: fb_clear while fb_ready=1 SHALL set fb_ready=0 and write fb_clear_value to addresses 0..19199, one per cycle.
REQ-019 fb_ready SHALL return to 1 on the cycle after address 19199 is written.
REQ-020 During a clear, fb_we SHALL be ignored; fb_clear while fb_ready=0 SHALL be ignored.
REQ-021 If fb_clear and fb_we are asserted in the same cycle while ready, the clear SHALL win and the write SHALL be dropped.
REQ-022 Display reads SHALL continue during a clear.

Reset
REQ-023 While rst_pix_n=0: sx=-160, sy=-45, all pipeline registers 0, fb_ready=1, clear FSM idle; sdl_* outputs 0 except sdl_hsync=1 and sdl_vsync=1.
REQ-024 RAM contents SHALL be unaffected by reset.
REQ-025 A reset asserted mid-clear SHALL abort the clear; addresses already written keep fb_clear_value.
REQ-026 First cycle after reset release: frame=1, line=1.

Verification
REQ-027 Release reset, count clocks -> frame pulses every 420000 cycles; line pulses every 800 cycles; hsync low for 96 cycles per line; vsync low for exactly 1600 cycles per frame.
REQ-028 Write 4'h5 at address 161; palette entry 5 = 12'hF00 -> at sdl_sx=1, sdl_sy=1: sdl_r=8'hFF, sdl_g=8'h00, sdl_b=8'h00.
REQ-029 Pixel at sdl_sx=160, sdl_sy=0, and any blanking pixel -> sdl_r=8'h11, sdl_g=8'h33, sdl_b=8'h77.
REQ-030 Pulse fb_clear with value 4'h2, default palette -> fb_ready low for exactly 19200 cycles; next frame window pixels = 8'h22 on all channels; fb_we pulses during the clear have no effect.
REQ-031 Assert reset mid-frame -> sdl_sx/sdl_sy sequence restarts at -160/-45 three cycles after release; RAM data written earlier is still displayed.
REQ-032 Write at address 19200 -> no visible pixel changes.
